// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 camera power path: runtime power
// controller state encoding, default 50 MHz timing constants (also used by
// the boot power-up sequencer) and small state-decode helpers.
package ov5640_pkg;

  // Runtime power controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_ACTIVE   = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_RST_HOLD = 3'd3,
    ST_PWDN_SET = 3'd4,
    ST_STANDBY  = 3'd5,
    ST_WAKE_PWR = 3'd6,
    ST_WAKE_SET = 3'd7
  } pwr_state_t;

  // Default timing at a 50 MHz system clock.
  localparam int DEF_CNT_W       = 21;
  localparam int DEF_RST_HOLD    = 50_000;     // 1 ms
  localparam int DEF_PWDN_SETTLE = 250_000;    // 5 ms
  localparam int DEF_WAKE_RST    = 100_000;    // 2 ms
  localparam int DEF_WAKE_SETTLE = 1_050_000;  // 21 ms

  // Registered output bundle of the power controller.
  typedef struct packed {
    logic pwdn;
    logic reset;
    logic ready;
    logic standby;
    logic busy;
  } pin_vec_t;

  // Pin/status levels owned by each state. BOOT returns the safe
  // power-down levels; the controller overrides the two sensor pins with
  // the boot sequencer's values while in BOOT.
  function automatic pin_vec_t state_pins(input pwr_state_t st);
    pin_vec_t p;
    p = '{pwdn: 1'b1, reset: 1'b0, ready: 1'b0, standby: 1'b0, busy: 1'b1};
    case (st)
      ST_BOOT:     p = '{pwdn: 1'b1, reset: 1'b0, ready: 1'b0, standby: 1'b0, busy: 1'b1};
      ST_ACTIVE:   p = '{pwdn: 1'b0, reset: 1'b1, ready: 1'b1, standby: 1'b0, busy: 1'b0};
      ST_DRAIN:    p = '{pwdn: 1'b0, reset: 1'b1, ready: 1'b0, standby: 1'b0, busy: 1'b1};
      ST_RST_HOLD: p = '{pwdn: 1'b0, reset: 1'b0, ready: 1'b0, standby: 1'b0, busy: 1'b1};
      ST_PWDN_SET: p = '{pwdn: 1'b1, reset: 1'b0, ready: 1'b0, standby: 1'b0, busy: 1'b1};
      ST_STANDBY:  p = '{pwdn: 1'b1, reset: 1'b0, ready: 1'b0, standby: 1'b1, busy: 1'b0};
      ST_WAKE_PWR: p = '{pwdn: 1'b0, reset: 1'b0, ready: 1'b0, standby: 1'b0, busy: 1'b1};
      ST_WAKE_SET: p = '{pwdn: 1'b0, reset: 1'b1, ready: 1'b0, standby: 1'b0, busy: 1'b1};
      default:     p = '{pwdn: 1'b1, reset: 1'b0, ready: 1'b0, standby: 1'b0, busy: 1'b1};
    endcase
    return p;
  endfunction

  // True for the states whose length is set by the delay counter.
  function automatic logic is_timed(input pwr_state_t st);
    return (st == ST_RST_HOLD) || (st == ST_PWDN_SET) ||
           (st == ST_WAKE_PWR) || (st == ST_WAKE_SET);
  endfunction

endpackage

// File: rtl/ov5640_pwr_seq_if.sv
// Bundle between the camera system logic and the runtime power controller.
// master: system side (boot sequencer, request source, SCCB engine).
// slave:  the power controller driving the sensor pins and status.
interface ov5640_pwr_seq_if;

  logic pu_pwdn;
  logic pu_reset;
  logic pu_done;
  logic req_down;
  logic req_up;
  logic sccb_busy;
  logic coms_pwdn;
  logic coms_reset;
  logic cam_ready;
  logic standby;
  logic busy;

  modport master (
    output pu_pwdn, pu_reset, pu_done, req_down, req_up, sccb_busy,
    input  coms_pwdn, coms_reset, cam_ready, standby, busy
  );

  modport slave (
    input  pu_pwdn, pu_reset, pu_done, req_down, req_up, sccb_busy,
    output coms_pwdn, coms_reset, cam_ready, standby, busy
  );

endinterface

// File: rtl/ov5640_dly_cnt.sv
// Generic state-length counter for timed sequencer states. The counter is
// cleared on state entry and counts while enabled; tc marks the cycle where
// cnt equals the terminal value (N-1), so a state that leaves on tc lasts
// exactly N cycles. The counter holds at the terminal value instead of
// wrapping.
module ov5640_dly_cnt #(
  parameter int CNT_W = 21
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = enable && (cnt == term);

  // Count up while enabled, restart from zero on clear, hold at terminal.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ov5640_pwr_seq.sv
// Runtime power controller for the OV5640 PWDN/RESETB pins. Passes the boot
// sequencer's pins through until boot completes, then runs the shutdown
// sequence (drain SCCB, hold reset, assert pwdn, settle) into standby and
// the wake sequence back to active. All outputs are registered from the
// current state, so they follow a state change by one cycle. Every delay
// parameter must be at least 1 and below 2**CNT_W.
import ov5640_pkg::*;

module ov5640_pwr_seq #(
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int PWDN_SETTLE = DEF_PWDN_SETTLE,
  parameter int WAKE_RST    = DEF_WAKE_RST,
  parameter int WAKE_SETTLE = DEF_WAKE_SETTLE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic            sysclk,
  input logic            rst_n,
  ov5640_pwr_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] TERM_RST_HOLD    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TERM_PWDN_SETTLE = CNT_W'(PWDN_SETTLE - 1);
  localparam logic [CNT_W-1:0] TERM_WAKE_RST    = CNT_W'(WAKE_RST - 1);
  localparam logic [CNT_W-1:0] TERM_WAKE_SETTLE = CNT_W'(WAKE_SETTLE - 1);

  pwr_state_t       state;
  pwr_state_t       state_next;
  logic             cnt_clear;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_tc;
  pin_vec_t         pins;
  pin_vec_t         pins_next;

  ov5640_dly_cnt #(
    .CNT_W (CNT_W)
  ) u_dly_cnt (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .term   (cnt_term),
    .tc     (cnt_tc)
  );

  // Select the length of the current timed state.
  always_comb begin
    cnt_en   = is_timed(state);
    cnt_term = '0;
    case (state)
      ST_RST_HOLD: cnt_term = TERM_RST_HOLD;
      ST_PWDN_SET: cnt_term = TERM_PWDN_SETTLE;
      ST_WAKE_PWR: cnt_term = TERM_WAKE_RST;
      ST_WAKE_SET: cnt_term = TERM_WAKE_SETTLE;
      default:     cnt_term = '0;
    endcase
  end

  // State register; BOOT is only ever re-entered through rst_n.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output decode. Requests outside their own state are
  // simply dropped; pu_done only matters while in BOOT.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:     if (bus.pu_done)    state_next = ST_ACTIVE;
      ST_ACTIVE:   if (bus.req_down)   state_next = ST_DRAIN;
      ST_DRAIN:    if (!bus.sccb_busy) state_next = ST_RST_HOLD;
      ST_RST_HOLD: if (cnt_tc)         state_next = ST_PWDN_SET;
      ST_PWDN_SET: if (cnt_tc)         state_next = ST_STANDBY;
      ST_STANDBY:  if (bus.req_up)     state_next = ST_WAKE_PWR;
      ST_WAKE_PWR: if (cnt_tc)         state_next = ST_WAKE_SET;
      ST_WAKE_SET: if (cnt_tc)         state_next = ST_ACTIVE;
      default:                         state_next = ST_BOOT;
    endcase

    cnt_clear = (state_next != state);

    pins_next = state_pins(state);
    if (state == ST_BOOT) begin
      pins_next.pwdn  = bus.pu_pwdn;
      pins_next.reset = bus.pu_reset;
    end
  end

  // Output register; reset drops the sensor straight into power-down.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pins <= state_pins(ST_BOOT);
    end else begin
      pins <= pins_next;
    end
  end

  assign bus.coms_pwdn  = pins.pwdn;
  assign bus.coms_reset = pins.reset;
  assign bus.cam_ready  = pins.ready;
  assign bus.standby    = pins.standby;
  assign bus.busy       = pins.busy;

endmodule

// File: tb/tb_ov5640_pwr_seq.sv
// Directed bench for the OV5640 runtime power controller with short delays.
// Each step drives inputs, queues the expected output vector
// {coms_pwdn, coms_reset, cam_ready, standby, busy} and compares it after
// the next rising edge.
module tb_ov5640_pwr_seq;
  import ov5640_pkg::*;

  localparam logic [4:0] V_BOOT10 = 5'b10001;
  localparam logic [4:0] V_BOOT01 = 5'b01001;
  localparam logic [4:0] V_ACT    = 5'b01100;
  localparam logic [4:0] V_DRAIN  = 5'b01001;
  localparam logic [4:0] V_RST    = 5'b00001;
  localparam logic [4:0] V_PWDN   = 5'b10001;
  localparam logic [4:0] V_STBY   = 5'b10010;
  localparam logic [4:0] V_WPWR   = 5'b00001;
  localparam logic [4:0] V_WSET   = 5'b01001;

  typedef struct {
    string      tag;
    logic [4:0] vec;
  } exp_t;

  logic sysclk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  ov5640_pwr_seq_if bus ();

  ov5640_pwr_seq #(
    .RST_HOLD    (4),
    .PWDN_SETTLE (8),
    .WAKE_RST    (3),
    .WAKE_SETTLE (6),
    .CNT_W       (21)
  ) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [4:0] pins();
    return {bus.coms_pwdn, bus.coms_reset, bus.cam_ready, bus.standby, bus.busy};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic cycle(input logic rd, input logic ru, input logic sbusy,
                       input logic [4:0] expv, input string tag);
    exp_t e;
    bus.req_down  = rd;
    bus.req_up    = ru;
    bus.sccb_busy = sbusy;
    e.tag = tag;
    e.vec = expv;
    sb.push_back(e);
    @(posedge sysclk);
    #1;
    e = sb.pop_front();
    check(e.tag, pins(), e.vec);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.pu_pwdn   = 1'b1;
    bus.pu_reset  = 1'b0;
    bus.pu_done   = 1'b0;
    bus.req_down  = 1'b0;
    bus.req_up    = 1'b0;
    bus.sccb_busy = 1'b0;
    @(posedge sysclk);
    #1;
    check("reset", pins(), V_BOOT10);
    rst_n = 1'b1;

    // Boot pass-through; requests during BOOT are dropped.
    cycle(1'b1, 1'b0, 1'b0, V_BOOT10, "boot_pwdn");
    bus.pu_pwdn  = 1'b0;
    bus.pu_reset = 1'b1;
    #1;
    check("boot_lag", pins(), V_BOOT10);
    cycle(1'b0, 1'b0, 1'b0, V_BOOT01, "boot_pass");
    cycle(1'b0, 1'b1, 1'b0, V_BOOT01, "boot_req_up");
    bus.pu_done = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, V_BOOT01, "boot_done");
    bus.pu_done = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, V_ACT, "active_entry");
    cycle(1'b0, 1'b1, 1'b0, V_ACT, "active_req_up");
    cycle(1'b0, 1'b0, 1'b0, V_ACT, "active_hold");

    // Shutdown with SCCB idle; both requests pulsed during PWDN_SET.
    cycle(1'b1, 1'b0, 1'b0, V_ACT, "shut_req");
    cycle(1'b0, 1'b0, 1'b0, V_DRAIN, "shut_drain");
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b0, V_RST, $sformatf("shut_rst_%0d", i));
    for (int i = 0; i < 8; i++)
      cycle(i == 3, i == 3, 1'b0, V_PWDN, $sformatf("shut_pwdn_%0d", i));
    cycle(1'b0, 1'b0, 1'b0, V_STBY, "stby_entry");
    cycle(1'b1, 1'b0, 1'b0, V_STBY, "stby_req_down");
    cycle(1'b0, 1'b0, 1'b0, V_STBY, "stby_hold");
    cycle(1'b0, 1'b0, 1'b0, V_STBY, "stby_hold2");

    // Wake back to active.
    cycle(1'b0, 1'b1, 1'b0, V_STBY, "wake_req");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b0, V_WPWR, $sformatf("wake_pwr_%0d", i));
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b0, 1'b0, V_WSET, $sformatf("wake_set_%0d", i));
    cycle(1'b0, 1'b0, 1'b0, V_ACT, "wake_active");
    cycle(1'b0, 1'b0, 1'b0, V_ACT, "wake_active2");

    // Shutdown waiting on a 10-cycle SCCB transaction.
    cycle(1'b1, 1'b0, 1'b1, V_ACT, "drain_req");
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b0, i < 9, V_DRAIN, $sformatf("drain_wait_%0d", i));
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 1'b0, 1'b0, V_RST, $sformatf("drain_rst_%0d", i));
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b0, 1'b0, V_PWDN, $sformatf("drain_pwdn_%0d", i));
    cycle(1'b0, 1'b0, 1'b0, V_STBY, "drain_stby");

    // Wake again and reset in the third WAKE_SET cycle.
    cycle(1'b0, 1'b1, 1'b0, V_STBY, "wake2_req");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b0, V_WPWR, $sformatf("wake2_pwr_%0d", i));
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 1'b0, 1'b0, V_WSET, $sformatf("wake2_set_%0d", i));
    rst_n = 1'b0;
    #2;
    check("rst_async", pins(), V_BOOT10);
    bus.pu_pwdn  = 1'b1;
    bus.pu_reset = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;

    // Back in BOOT awaiting pu_done.
    cycle(1'b1, 1'b0, 1'b0, V_BOOT10, "post_rst_boot");
    cycle(1'b0, 1'b0, 1'b0, V_BOOT10, "post_rst_hold");
    bus.pu_pwdn  = 1'b0;
    bus.pu_reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, V_BOOT01, "post_rst_pass");
    cycle(1'b0, 1'b0, 1'b0, V_BOOT01, "post_rst_wait");
    bus.pu_done = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, V_BOOT01, "post_rst_done");
    cycle(1'b0, 1'b0, 1'b0, V_ACT, "post_rst_active");

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov5640_pwr_seq.md
Name: ov5640_pwr_seq

Overview:
- Runtime power controller for the OV5640 sensor pins. It sits after the boot power-up sequencer and owns coms_pwdn/coms_reset once boot completes.
- Passes the boot sequence through, then performs the reverse (shutdown) sequence into standby on request, and a wake sequence back to active.
- The SCCB/streaming control logic uses cam_ready/standby to gate register access.

Parameters:
- RST_HOLD, 50_000, cycles coms_reset held low before asserting coms_pwdn on shutdown (1 ms @ 50 MHz).
- PWDN_SETTLE, 250_000, cycles after coms_pwdn high before entering STANDBY (5 ms).
- WAKE_RST, 100_000, cycles coms_pwdn low with coms_reset low on wake (2 ms).
- WAKE_SETTLE, 1_050_000, cycles after coms_reset high before cam_ready (21 ms).
- CNT_W, 21, delay counter width; every delay parameter must be ≥1 and <2^CNT_W.

Ports:
- sysclk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- pu_pwdn  in  1  pwdn from boot power-up sequencer
- pu_reset  in  1  reset from boot power-up sequencer
- pu_done  in  1  boot sequence complete (sticky until rst_n)
- req_down  in  1  single-cycle request: enter standby
- req_up  in  1  single-cycle request: wake from standby
- sccb_busy  in  1  SCCB transaction in flight; shutdown waits for it to clear
- coms_pwdn  out  1  sensor PWDN pin, active-high
- coms_reset  out  1  sensor RESETB pin, active-low
- cam_ready  out  1  sensor powered and settled, SCCB access allowed
- standby  out  1  sensor in power-down
- busy  out  1  sequence in progress (any state except ACTIVE/STANDBY)

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=BOOT, cnt=0.
  - Outputs: coms_pwdn=1, coms_reset=0, cam_ready=0, standby=0, busy=1.
- All outputs are registered. Pin outputs change one cycle after the state or input that drives them.
- Delay counter:
  - Cleared on every state entry.
  - Increments each cycle while in a timed state.
  - Timed state exits when cnt==N-1, so the state occupies exactly N cycles.
- States and transitions:
  - BOOT: coms_pwdn<=pu_pwdn and coms_reset<=pu_reset (registered pass-through). On pu_done=1, go to ACTIVE.
  - ACTIVE: pwdn=0, reset=1, cam_ready=1, busy=0. On req_down, go to DRAIN.
  - DRAIN: cam_ready=0, busy=1, pins unchanged. When sccb_busy=0, go to RST_HOLD. If sccb_busy is already 0 on entry, DRAIN lasts 1 cycle.
  - RST_HOLD: reset=0, pwdn=0, for RST_HOLD cycles, then PWDN_SET.
  - PWDN_SET: reset=0, pwdn=1, for PWDN_SETTLE cycles, then STANDBY.
  - STANDBY: pwdn=1, reset=0, standby=1, busy=0. On req_up, go to WAKE_PWR.
  - WAKE_PWR: standby=0, busy=1, pwdn=0, reset=0, for WAKE_RST cycles, then WAKE_SET.
  - WAKE_SET: pwdn=0, reset=1, for WAKE_SETTLE cycles, then ACTIVE.
- Request rules:
  - req_down is honoured only in ACTIVE; req_up only in STANDBY.
  - Requests are dropped, not queued, in every other state, including BOOT.
  - req_down and req_up in the same cycle: only the one valid for the current state acts.
- pu_done deasserting after BOOT is ignored; the block never re-enters BOOT except via rst_n.
- Invariant: coms_pwdn=1 and coms_reset=1 are never driven together outside BOOT pass-through.
- Reset mid-sequence: pins jump immediately to pwdn=1, reset=0. The boot sequencer restarts independently.
- Counter never wraps; the exit compare caps it.

Decomposition:
- Shared package ov5640_pkg:
  - state encoding (3-bit: BOOT, ACTIVE, DRAIN, RST_HOLD, PWDN_SET, STANDBY, WAKE_PWR, WAKE_SET);
  - default 50 MHz timing constants, reused by ov5640_powerup's delays.
- One natural sub-module: ov5640_dly_cnt.
  - Inputs: clear, enable, terminal value.
  - Output: tc pulse at cnt==N-1.
  - Reusable by other timed blocks in the camera path.

Test Plan (sim params RST_HOLD=4, PWDN_SETTLE=8, WAKE_RST=3, WAKE_SETTLE=6):
- Boot pass-through:
  - Drive pu_pwdn=1/pu_reset=0, then pu_pwdn=0, pu_reset=1, pu_done=1.
  - Pins follow with 1-cycle lag; cam_ready=1 the cycle after ACTIVE entry; busy=0.
- Shutdown:
  - req_down pulse in ACTIVE with sccb_busy=0.
  - cam_ready=0 next cycle; reset=0 held 4 cycles with pwdn=0; then pwdn=1 for 8 cycles; then standby=1, busy=0.
- SCCB drain:
  - req_down while sccb_busy=1 for 10 cycles.
  - Pins unchanged (pwdn=0, reset=1) through those 10 cycles; RST_HOLD starts the cycle after sccb_busy falls.
- Wake:
  - req_up in STANDBY.
  - pwdn=0/reset=0 for 3 cycles; reset=1 for 6 cycles; then cam_ready=1; standby=0 throughout.
- Ignored requests:
  - req_up in ACTIVE, req_down in STANDBY, both during PWDN_SET, req_down during BOOT.
  - No state change; checker confirms no extra transitions.
- Reset mid-sequence:
  - Assert rst_n=0 during WAKE_SET cycle 3.
  - Asynchronously pwdn=1, reset=0, cam_ready=0, standby=0, busy=1; after release, state=BOOT awaiting pu_done.
